cpu_sequencer: RTL

Multi-cycle control FSM that sequences the 8-bit accumulator/register-file CPU datapath. Each instruction is fetched from external instruction memory over a req/ack handshake, then decoded. The block then drives the ALU select, the operand muxes, register-file write, and SRAM chip-select/read/write strobes. It owns the program counter and replaces the free-running PC adder path. It sits between instruction memory and the datapath.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/cpu_decoder.sv | 36 +++
 rtl/cpu_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the CPU sequencer: opcodes, ALU selects,
// instruction classes and FSM state encoding.
package cpu_pkg;

  localparam int PC_STEP = 4;

  localparam logic [3:0] OPC_LDI  = 4'd0;
  localparam logic [3:0] OPC_MOV  = 4'd1;
  localparam logic [3:0] OPC_ADD  = 4'd2;
  localparam logic [3:0] OPC_SUB  = 4'd3;
  localparam logic [3:0] OPC_AND  = 4'd4;
  localparam logic [3:0] OPC_OR   = 4'd5;
  localparam logic [3:0] OPC_SRL  = 4'd6;
  localparam logic [3:0] OPC_LD   = 4'd7;
  localparam logic [3:0] OPC_ST   = 4'd8;
  localparam logic [3:0] OPC_HALT = 4'd15;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;

  // Instruction class: selects the path the FSM takes after DECODE
  localparam logic [2:0] CLS_ALU  = 3'd0;
  localparam logic [2:0] CLS_LD   = 3'd1;
  localparam logic [2:0] CLS_ST   = 3'd2;
  localparam logic [2:0] CLS_HALT = 3'd3;
  localparam logic [2:0] CLS_ILL  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder: opcode -> ALU select, operand controls,
// instruction class and illegal flag.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_op_o,
  output logic       is_add_o,
  output logic       is_imm_o,
  output logic [2:0] cls_o,
  output logic       illegal_o
);

  // Opcode table lookup; anything not listed is illegal
  always_comb begin
    alu_op_o  = ALU_FWD;
    is_add_o  = 1'b0;
    is_imm_o  = 1'b0;
    cls_o     = CLS_ILL;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LDI:  begin is_add_o = 1'b1; is_imm_o = 1'b1; cls_o = CLS_ALU; end
      OPC_MOV:  begin is_add_o = 1'b1; cls_o = CLS_ALU; end
      OPC_ADD:  begin alu_op_o = ALU_ADD; is_add_o = 1'b1; cls_o = CLS_ALU; end
      OPC_SUB:  begin alu_op_o = ALU_ADD; cls_o = CLS_ALU; end
      OPC_AND:  begin alu_op_o = ALU_AND; is_add_o = 1'b1; cls_o = CLS_ALU; end
      OPC_OR:   begin alu_op_o = ALU_OR;  is_add_o = 1'b1; cls_o = CLS_ALU; end
      OPC_SRL:  begin alu_op_o = ALU_SRL; is_add_o = 1'b1; cls_o = CLS_ALU; end
      OPC_LD:   begin is_add_o = 1'b1; cls_o = CLS_LD; end
      OPC_ST:   begin is_add_o = 1'b1; cls_o = CLS_ST; end
      OPC_HALT: cls_o = CLS_HALT;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit CPU datapath. Owns PC, IR and the
// retired-instruction counter; fetches over a req/ack handshake.
//
//   state  | meaning
//   IDLE   | waiting for START
//   FETCH  | request held on IMEM_ADDR = PC until ack captures IR
//   DECODE | IR decoded, decode outputs valid; illegal retires here
//   EXEC   | ALU result written back (REG_WE)
//   MEM    | SRAM access; ST retires here, LD continues to WB
//   WB     | SRAM data written back (REG_WE, WB_SEL)
//   HALT   | stopped until reset
module cpu_sequencer #(
  parameter int PC_W    = 9,
  parameter int PC_STEP = cpu_pkg::PC_STEP
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [8:0]      IMEM_DATA,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      ALU_OP,
  output logic            IS_ADD,
  output logic            IS_IMM,
  output logic [7:0]      IMM,
  output logic [2:0]      DEST,
  output logic [2:0]      SRC1,
  output logic [2:0]      SRC2,
  output logic            REG_WE,
  output logic            WB_SEL,
  output logic            SRAM_CS,
  output logic            SRAM_RD,
  output logic            SRAM_WE,
  output logic            HALTED,
  output logic            ILLEGAL,
  output logic [15:0]     INSTR_CNT
);
  import cpu_pkg::*;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ill_q, ill_d;

  logic [2:0] dec_alu_op;
  logic       dec_is_add;
  logic       dec_is_imm;
  logic [2:0] dec_cls;
  logic       dec_illegal;
  logic       dec_valid;

  cpu_decoder u_dec (
    .opcode_i  (ir_q[4:1]),
    .alu_op_o  (dec_alu_op),
    .is_add_o  (dec_is_add),
    .is_imm_o  (dec_is_imm),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  // Next state, PC/IR capture and retire counting
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          pc_d    = pc_q + STEP;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          ill_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_FETCH;
        end else if (dec_cls == CLS_HALT) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_HALT;
        end else if (dec_cls == CLS_ALU) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_EXEC: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (dec_cls == CLS_LD) begin
          state_d = ST_WB;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decoded from the registered state; decode outputs held at zero
  // until an instruction has actually been captured
  always_comb begin
    IMEM_REQ  = 1'b0;
    REG_WE    = 1'b0;
    WB_SEL    = 1'b0;
    SRAM_CS   = 1'b0;
    SRAM_RD   = 1'b0;
    SRAM_WE   = 1'b0;
    HALTED    = 1'b0;
    dec_valid = (state_q != ST_IDLE) && (state_q != ST_FETCH);
    case (state_q)
      ST_FETCH: IMEM_REQ = 1'b1;
      ST_EXEC:  REG_WE = 1'b1;
      ST_MEM: begin
        SRAM_CS = 1'b1;
        SRAM_RD = (dec_cls == CLS_LD);
        SRAM_WE = (dec_cls == CLS_ST);
      end
      ST_WB: begin
        REG_WE = 1'b1;
        WB_SEL = 1'b1;
      end
      ST_HALT:  HALTED = 1'b1;
      default:  ;
    endcase
    ALU_OP = dec_valid ? dec_alu_op : ALU_FWD;
    IS_ADD = dec_valid & dec_is_add;
    IS_IMM = dec_valid & dec_is_imm;
  end

  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign IMM       = ir_q[7:0];
  assign DEST      = {1'b0, ir_q[6:5]};
  assign SRC1      = {1'b0, ir_q[8:7]};
  assign SRC2      = {1'b0, ir_q[1:0]};
  assign ILLEGAL   = ill_q;
  assign INSTR_CNT = cnt_q;

endmodule
